reg_status_ctrl: RTL and testbench
==================================

# reg_status_ctrl

Register-status controller for the out-of-order core. It owns the busy bit and reorder tag for each of the 32 architectural registers. It applies rename requests from ID and in-order commits from the ROB, answers source-operand status queries for dispatch with same-cycle commit forwarding, and drives the single regfile write port. A ROB flush returns every register to the non-busy state.

## Interface
- `REG_NUM`, 32: number of architectural registers; x0 is hard-wired zero.
- `TAG_W`, 4: width of a ROB reorder tag.
- `DATA_W`, 32: width of register data.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `rdy`  in  1  global enable; when low, all state is frozen.
- `id_dest_valid`  in  1  ID is renaming a destination this cycle.
- `id_dest_addr`  in  5  destination register index.
- `id_dest_tag`  in  TAG_W  ROB entry allocated to the destination.
- `rob_commit_valid`  in  1  ROB head commits this cycle.
- `rob_commit_addr`  in  5  committed destination register.
- `rob_commit_tag`  in  TAG_W  ROB tag of the committing entry.
- `rob_commit_data`  in  DATA_W  committed result.
- `rob_flush`  in  1  mispredict or exception flush; one-cycle pulse.
- `q1_addr`, `q2_addr`  in  5 each  source register indices from dispatch.
- `q1_busy`, `q2_busy`  out  1 each  source is waiting on a tag (combinational).
- `q1_tag`, `q2_tag`  out  TAG_W each  producing tag; 0 when not busy.
- `q1_fwd`, `q2_fwd`  out  1 each  value is forwarded from this cycle's commit.
- `q1_fwd_data`, `q2_fwd_data`  out  DATA_W each  forwarded value; 0 when fwd=0.
- `rf_we`  out  1  regfile write enable (registered).
- `rf_waddr`  out  5  regfile write index (registered).
- `rf_wdata`  out  DATA_W  regfile write data (registered).
- `id_stall`  out  1  ID must hold its rename; high during the FLUSH state.
- `busy_count`  out  6  number of busy registers (registered).

## Operation
- **State per register:** `busy[i]` (1 bit) and `tag[i]` (TAG_W bits). Register x0 is never busy; renames and commits to x0 are ignored.
- **FSM states:**
  - RUN → FLUSH on `rob_flush` while `rdy` is high.
  - FLUSH → RUN unconditionally on the next `rdy` edge.
  - `id_stall` = (state==FLUSH).
- **Rename** (RUN only; dropped in FLUSH and in the `rob_flush` cycle): `busy[a]<=1`, `tag[a]<=id_dest_tag`.
- **Commit:**
  - Clears `busy[a]` and `tag[a]` only if `busy[a]` is set and `tag[a]==rob_commit_tag`. A mismatched tag means a younger rename owns the register, so busy and tag are left unchanged.
  - Always issues a regfile write: `rf_we<=1`, `rf_waddr<=a`, `rf_wdata<=data` (x0 excluded).
- **Rename and commit to the same register in the same cycle:** the rename wins; busy stays 1 and the tag takes the new value.
- **Flush:**
  - All busy bits and tags are cleared at the edge; `busy_count<=0`.
  - A commit in the same cycle still produces its regfile write.
  - A rename in the same cycle is dropped.
- **Query port** (for each q):
  - Addr 0: busy=0, tag=0, fwd=0.
  - Else if `rob_commit_valid` && addr==commit addr && `busy[addr]` && `tag[addr]==rob_commit_tag`: busy=0, fwd=1, fwd_data=`rob_commit_data`.
  - Otherwise: busy=`busy[addr]`, tag=`busy ? tag[addr] : 0`, fwd=0.
  - Same-cycle renames are not visible to queries.
- **busy_count:**
  - +1 when a rename targets a non-busy register.
  - −1 when a commit clears a register.
  - Net 0 when both happen in the same cycle.
  - Saturating arithmetic is not needed; the count cannot exceed 31.
- **rdy low:** no state change and rename/commit inputs are ignored; `rf_we<=0` at the next edge; query outputs still evaluate.

## Timing
- **Reset values:** all busy=0, all tags=0, state RUN, `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `busy_count`=0, `id_stall`=0. Query outputs read 0 for busy, tag, fwd and fwd_data.
- **Reset mid-operation:** takes effect immediately and asynchronously, including from FLUSH and with `rf_we` high.
- **Rename:** visible to queries from the cycle after the edge.
- **Commit:**
  - Forwarding is visible in the same cycle (combinational).
  - Busy clears at the edge.
  - `rf_we` is high for exactly one cycle after each valid commit (one-cycle write latency).
- **Flush:** busy cleared at edge N; `id_stall` is high for cycle N+1 only; renames are accepted again from N+2.

## Test plan
- Reset, then query x5 → q1_busy=0, q1_tag=0, rf_we=0, busy_count=0.
- Rename x5 tag 3, next cycle query x5 → busy=1, tag=3, busy_count=1. Commit x5 tag 3 data 0xDEADBEEF → same cycle fwd=1, fwd_data=0xDEADBEEF. Next cycle: rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, busy=0, busy_count=0.
- Rename x7 tag 1, then rename x7 tag 4, then commit x7 tag 1 → x7 stays busy with tag 4, rf write of x7 still occurs, busy_count=1.
- Same cycle: rename x9 tag 6 and commit x9 matching the old tag 2 → x9 busy, tag 6, busy_count unchanged.
- Rename x1, x2, x3, then pulse rob_flush together with rename x4 → all queries not busy, busy_count=0, id_stall=1 for one cycle, x4 not busy. A rename on the following cycle is accepted.
- Hold rdy=0 while driving a rename and a commit → no state change and rf_we=0. Rename and commit to x0 → x0 never busy and no rf write.

Source files
------------

// File: rtl/reg_status_ctrl.sv
`default_nettype none
// ============================================================================
// Module : reg_status_ctrl
// Busy/tag scoreboard for the architectural registers, with commit forwarding.
// Rev    : 1.0
// ============================================================================
module reg_status_ctrl #(
    parameter int REG_NUM = 32,
    parameter int TAG_W   = 4,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              id_dest_valid,
    input  logic [4:0]        id_dest_addr,
    input  logic [TAG_W-1:0]  id_dest_tag,
    input  logic              rob_commit_valid,
    input  logic [4:0]        rob_commit_addr,
    input  logic [TAG_W-1:0]  rob_commit_tag,
    input  logic [DATA_W-1:0] rob_commit_data,
    input  logic              rob_flush,
    input  logic [4:0]        q1_addr,
    input  logic [4:0]        q2_addr,
    output logic              q1_busy,
    output logic              q2_busy,
    output logic [TAG_W-1:0]  q1_tag,
    output logic [TAG_W-1:0]  q2_tag,
    output logic              q1_fwd,
    output logic              q2_fwd,
    output logic [DATA_W-1:0] q1_fwd_data,
    output logic [DATA_W-1:0] q2_fwd_data,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              id_stall,
    output logic [5:0]        busy_count
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [REG_NUM-1:0] busy_q, busy_d;
    logic [TAG_W-1:0]   tag_q [REG_NUM];
    logic [TAG_W-1:0]   tag_d [REG_NUM];
    logic [5:0]         busy_count_q, busy_count_d;
    logic               rf_we_q;
    logic [4:0]         rf_waddr_q;
    logic [DATA_W-1:0]  rf_wdata_q;

    logic w_flush, w_rename, w_commit, w_commit_hit, w_q1_hit, w_q2_hit;

    assign w_flush      = rdy && rob_flush;
    assign w_rename     = rdy && id_dest_valid && (id_dest_addr != 5'd0)
                          && (state_q == ST_RUN) && !rob_flush;
    assign w_commit     = rdy && rob_commit_valid && (rob_commit_addr != 5'd0);
    // Only the owning tag may retire the busy bit; a stale tag leaves the younger rename alone.
    assign w_commit_hit = w_commit && busy_q[rob_commit_addr]
                          && (tag_q[rob_commit_addr] == rob_commit_tag);

    always_comb begin
        busy_d  = busy_q;
        tag_d   = tag_q;
        state_d = state_q;
        if (w_flush) begin
            busy_d = '0;
            for (int i = 0; i < REG_NUM; i++) begin
                tag_d[i] = '0;
            end
        end else begin
            if (w_commit_hit) begin
                busy_d[rob_commit_addr] = 1'b0;
                tag_d[rob_commit_addr]  = '0;
            end
            // Applied after the commit so a same-register rename wins.
            if (w_rename) begin
                busy_d[id_dest_addr] = 1'b1;
                tag_d[id_dest_addr]  = id_dest_tag;
            end
        end
        if (rdy) begin
            if (state_q == ST_FLUSH) begin
                state_d = ST_RUN;
            end else if (rob_flush) begin
                state_d = ST_FLUSH;
            end
        end
        busy_count_d = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            busy_count_d = busy_count_d + 6'(busy_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            busy_q       <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                tag_q[i] <= '0;
            end
            busy_count_q <= '0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
        end else begin
            rf_we_q <= w_commit;
            if (w_commit) begin
                rf_waddr_q <= rob_commit_addr;
                rf_wdata_q <= rob_commit_data;
            end
            if (rdy) begin
                state_q      <= state_d;
                busy_q       <= busy_d;
                tag_q        <= tag_d;
                busy_count_q <= busy_count_d;
            end
        end
    end

    assign w_q1_hit    = w_commit_hit && (q1_addr == rob_commit_addr);
    assign w_q2_hit    = w_commit_hit && (q2_addr == rob_commit_addr);

    assign q1_busy     = (q1_addr != 5'd0) && busy_q[q1_addr] && !w_q1_hit;
    assign q2_busy     = (q2_addr != 5'd0) && busy_q[q2_addr] && !w_q2_hit;
    assign q1_tag      = q1_busy ? tag_q[q1_addr] : '0;
    assign q2_tag      = q2_busy ? tag_q[q2_addr] : '0;
    assign q1_fwd      = w_q1_hit;
    assign q2_fwd      = w_q2_hit;
    assign q1_fwd_data = w_q1_hit ? rob_commit_data : '0;
    assign q2_fwd_data = w_q2_hit ? rob_commit_data : '0;

    assign rf_we       = rf_we_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;
    assign id_stall    = (state_q == ST_FLUSH);
    assign busy_count  = busy_count_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_status_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_reg_status_ctrl
// Directed scenarios plus randomized traffic against a register-status model.
// Rev    : 1.0
// ============================================================================
module tb_reg_status_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy;
    logic        id_dest_valid;
    logic [4:0]  id_dest_addr;
    logic [3:0]  id_dest_tag;
    logic        rob_commit_valid;
    logic [4:0]  rob_commit_addr;
    logic [3:0]  rob_commit_tag;
    logic [31:0] rob_commit_data;
    logic        rob_flush;
    logic [4:0]  q1_addr, q2_addr;
    logic        q1_busy, q2_busy, q1_fwd, q2_fwd;
    logic [3:0]  q1_tag, q2_tag;
    logic [31:0] q1_fwd_data, q2_fwd_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        id_stall;
    logic [5:0]  busy_count;

    int errors = 0;
    int checks = 0;

    reg_status_ctrl #(.REG_NUM(32), .TAG_W(4), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .id_dest_valid(id_dest_valid), .id_dest_addr(id_dest_addr), .id_dest_tag(id_dest_tag),
        .rob_commit_valid(rob_commit_valid), .rob_commit_addr(rob_commit_addr),
        .rob_commit_tag(rob_commit_tag), .rob_commit_data(rob_commit_data),
        .rob_flush(rob_flush), .q1_addr(q1_addr), .q2_addr(q2_addr),
        .q1_busy(q1_busy), .q2_busy(q2_busy), .q1_tag(q1_tag), .q2_tag(q2_tag),
        .q1_fwd(q1_fwd), .q2_fwd(q2_fwd), .q1_fwd_data(q1_fwd_data), .q2_fwd_data(q2_fwd_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .id_stall(id_stall), .busy_count(busy_count)
    );

    always #5 clk = ~clk;

    task automatic idle();
        rdy              = 1'b1;
        id_dest_valid    = 1'b0;
        id_dest_addr     = 5'd0;
        id_dest_tag      = 4'd0;
        rob_commit_valid = 1'b0;
        rob_commit_addr  = 5'd0;
        rob_commit_tag   = 4'd0;
        rob_commit_data  = 32'd0;
        rob_flush        = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rename(input logic [4:0] a, input logic [3:0] t);
        id_dest_valid = 1'b1;
        id_dest_addr  = a;
        id_dest_tag   = t;
    endtask

    task automatic commit(input logic [4:0] a, input logic [3:0] t, input logic [31:0] d);
        rob_commit_valid = 1'b1;
        rob_commit_addr  = a;
        rob_commit_tag   = t;
        rob_commit_data  = d;
    endtask

    task automatic test_reset();
        idle();
        q1_addr = 5'd5;
        q2_addr = 5'd0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++; if (q1_busy !== 1'b0) begin errors++; $display("FAIL reset_q1_busy: got %0h expected 0", q1_busy); end
        checks++; if (q1_tag !== 4'd0) begin errors++; $display("FAIL reset_q1_tag: got %0h expected 0", q1_tag); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %0h expected 0", rf_we); end
        checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL reset_busy_count: got %0d expected 0", busy_count); end
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL reset_id_stall: got %0h expected 0", id_stall); end
        checks++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin errors++;
            $display("FAIL reset_rf_addr_data: got %0h/%0h expected 0/0", rf_waddr, rf_wdata); end
    endtask

    task automatic test_rename_commit();
        idle();
        rename(5'd5, 4'd3);
        tick();
        idle();
        q1_addr = 5'd5;
        #1;
        checks++; if (q1_busy !== 1'b1 || q1_tag !== 4'd3) begin errors++;
            $display("FAIL rename_visible: got busy=%0h tag=%0h expected busy=1 tag=3", q1_busy, q1_tag); end
        checks++; if (busy_count !== 6'd1) begin errors++; $display("FAIL rename_count: got %0d expected 1", busy_count); end
        commit(5'd5, 4'd3, 32'hDEADBEEF);
        #1;
        checks++; if (q1_fwd !== 1'b1 || q1_fwd_data !== 32'hDEADBEEF || q1_busy !== 1'b0) begin errors++;
            $display("FAIL commit_fwd: got fwd=%0h data=%0h busy=%0h expected 1/deadbeef/0", q1_fwd, q1_fwd_data, q1_busy); end
        tick();
        idle();
        #1;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin errors++;
            $display("FAIL commit_rf_write: got we=%0h addr=%0d data=%0h expected 1/5/deadbeef", rf_we, rf_waddr, rf_wdata); end
        checks++; if (q1_busy !== 1'b0 || q1_fwd !== 1'b0 || busy_count !== 6'd0) begin errors++;
            $display("FAIL commit_clear: got busy=%0h fwd=%0h count=%0d expected 0/0/0", q1_busy, q1_fwd, busy_count); end
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rf_we_one_cycle: got %0h expected 0", rf_we); end
    endtask

    task automatic test_tag_mismatch();
        idle();
        rename(5'd7, 4'd1);
        tick();
        rename(5'd7, 4'd4);
        tick();
        idle();
        commit(5'd7, 4'd1, 32'h0000_1234);
        q1_addr = 5'd7;
        #1;
        checks++; if (q1_fwd !== 1'b0 || q1_busy !== 1'b1 || q1_tag !== 4'd4) begin errors++;
            $display("FAIL stale_commit_query: got fwd=%0h busy=%0h tag=%0h expected 0/1/4", q1_fwd, q1_busy, q1_tag); end
        tick();
        idle();
        #1;
        checks++; if (q1_busy !== 1'b1 || q1_tag !== 4'd4 || busy_count !== 6'd1) begin errors++;
            $display("FAIL stale_commit_state: got busy=%0h tag=%0h count=%0d expected 1/4/1", q1_busy, q1_tag, busy_count); end
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h0000_1234) begin errors++;
            $display("FAIL stale_commit_write: got we=%0h addr=%0d data=%0h expected 1/7/1234", rf_we, rf_waddr, rf_wdata); end
    endtask

    task automatic test_back_to_back();
        idle();
        rename(5'd9, 4'd2);
        tick();
        rename(5'd9, 4'd6);
        commit(5'd9, 4'd2, 32'hA5A5_0009);
        q2_addr = 5'd9;
        #1;
        checks++; if (q2_fwd !== 1'b1 || q2_fwd_data !== 32'hA5A5_0009) begin errors++;
            $display("FAIL same_cycle_fwd: got fwd=%0h data=%0h expected 1/a5a50009", q2_fwd, q2_fwd_data); end
        tick();
        idle();
        #1;
        checks++; if (q2_busy !== 1'b1 || q2_tag !== 4'd6 || busy_count !== 6'd2) begin errors++;
            $display("FAIL rename_wins: got busy=%0h tag=%0h count=%0d expected 1/6/2", q2_busy, q2_tag, busy_count); end
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9) begin errors++;
            $display("FAIL rename_wins_write: got we=%0h addr=%0d expected 1/9", rf_we, rf_waddr); end
    endtask

    task automatic test_flush();
        idle();
        for (int i = 1; i <= 3; i++) begin
            rename(5'(i), 4'(i));
            tick();
        end
        checks++; if (busy_count !== 6'd5) begin errors++; $display("FAIL pre_flush_count: got %0d expected 5", busy_count); end
        idle();
        rob_flush = 1'b1;
        rename(5'd4, 4'd5);
        tick();
        idle();
        q1_addr = 5'd4;
        q2_addr = 5'd1;
        #1;
        checks++; if (id_stall !== 1'b1 || busy_count !== 6'd0) begin errors++;
            $display("FAIL flush_state: got stall=%0h count=%0d expected 1/0", id_stall, busy_count); end
        checks++; if (q1_busy !== 1'b0 || q2_busy !== 1'b0) begin errors++;
            $display("FAIL flush_clear: got x4=%0h x1=%0h expected 0/0", q1_busy, q2_busy); end
        rename(5'd6, 4'd7);
        tick();
        idle();
        q1_addr = 5'd6;
        #1;
        checks++; if (id_stall !== 1'b0 || q1_busy !== 1'b0 || busy_count !== 6'd0) begin errors++;
            $display("FAIL flush_stall_drop: got stall=%0h busy=%0h count=%0d expected 0/0/0", id_stall, q1_busy, busy_count); end
        rename(5'd8, 4'd2);
        tick();
        idle();
        q1_addr = 5'd8;
        #1;
        checks++; if (q1_busy !== 1'b1 || q1_tag !== 4'd2 || busy_count !== 6'd1) begin errors++;
            $display("FAIL post_flush_rename: got busy=%0h tag=%0h count=%0d expected 1/2/1", q1_busy, q1_tag, busy_count); end
    endtask

    task automatic test_rdy_low();
        idle();
        rdy = 1'b0;
        rename(5'd12, 4'd3);
        commit(5'd8, 4'd2, 32'h1111_2222);
        rob_flush = 1'b1;
        tick();
        checks++; if (rf_we !== 1'b0 || id_stall !== 1'b0) begin errors++;
            $display("FAIL rdy_low_outputs: got we=%0h stall=%0h expected 0/0", rf_we, id_stall); end
        tick();
        idle();
        q1_addr = 5'd12;
        q2_addr = 5'd8;
        #1;
        checks++; if (q1_busy !== 1'b0 || q2_busy !== 1'b1 || q2_tag !== 4'd2 || busy_count !== 6'd1) begin errors++;
            $display("FAIL rdy_low_frozen: got x12=%0h x8=%0h tag=%0h count=%0d expected 0/1/2/1",
                     q1_busy, q2_busy, q2_tag, busy_count); end
    endtask

    task automatic test_x0();
        idle();
        rename(5'd0, 4'd5);
        commit(5'd0, 4'd0, 32'hFFFF_0000);
        q1_addr = 5'd0;
        #1;
        checks++; if (q1_busy !== 1'b0 || q1_fwd !== 1'b0 || q1_tag !== 4'd0 || q1_fwd_data !== 32'd0) begin errors++;
            $display("FAIL x0_query: got busy=%0h fwd=%0h tag=%0h data=%0h expected zeros", q1_busy, q1_fwd, q1_tag, q1_fwd_data); end
        tick();
        idle();
        #1;
        checks++; if (rf_we !== 1'b0 || q1_busy !== 1'b0 || busy_count !== 6'd1) begin errors++;
            $display("FAIL x0_ignored: got we=%0h busy=%0h count=%0d expected 0/0/1", rf_we, q1_busy, busy_count); end
    endtask

    task automatic test_async_reset();
        idle();
        rename(5'd10, 4'd9);
        tick();
        idle();
        commit(5'd8, 4'd2, 32'h0BAD_F00D);
        tick();
        idle();
        q1_addr = 5'd10;
        #1;
        checks++; if (rf_we !== 1'b1 || busy_count !== 6'd1) begin errors++;
            $display("FAIL pre_async_reset: got we=%0h count=%0d expected 1/1", rf_we, busy_count); end
        rst = 1'b1;
        #1;
        checks++; if (rf_we !== 1'b0 || busy_count !== 6'd0 || q1_busy !== 1'b0 || rf_waddr !== 5'd0) begin errors++;
            $display("FAIL async_reset_run: got we=%0h count=%0d busy=%0h addr=%0d expected 0/0/0/0",
                     rf_we, busy_count, q1_busy, rf_waddr); end
        rst = 1'b0;
        rob_flush = 1'b1;
        tick();
        idle();
        #1;
        rst = 1'b1;
        #1;
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL async_reset_flush: got stall=%0h expected 0", id_stall); end
        rst = 1'b0;
    endtask

    // Model: per-register busy/tag arrays plus a flush-stall flag, advanced by the rules directly.
    task automatic test_random();
        logic       m_busy [32];
        logic [3:0] m_tag  [32];
        logic       m_stall, m_we, hit;
        logic [4:0] m_waddr;
        logic [31:0] m_wdata;
        logic       eb;
        logic [4:0] qa;
        int         cnt;
        idle();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            m_busy[i] = 1'b0;
            m_tag[i]  = 4'd0;
        end
        m_stall = 1'b0;
        m_we    = 1'b0;
        m_waddr = 5'd0;
        m_wdata = 32'd0;
        for (int n = 0; n < 400; n++) begin
            rdy              = ($urandom_range(0, 7) != 0);
            id_dest_valid    = 1'($urandom_range(0, 1));
            id_dest_addr     = 5'($urandom_range(0, 7));
            id_dest_tag      = 4'($urandom);
            rob_commit_valid = 1'($urandom_range(0, 1));
            rob_commit_addr  = 5'($urandom_range(0, 7));
            rob_commit_tag   = ($urandom_range(0, 2) != 0) ? m_tag[rob_commit_addr] : 4'($urandom);
            rob_commit_data  = $urandom;
            rob_flush        = ($urandom_range(0, 15) == 0);
            q1_addr          = ($urandom_range(0, 1) != 0) ? rob_commit_addr : 5'($urandom_range(0, 7));
            q2_addr          = 5'($urandom_range(0, 7));
            #1;
            hit = rdy && rob_commit_valid && (rob_commit_addr != 5'd0)
                  && m_busy[rob_commit_addr] && (m_tag[rob_commit_addr] == rob_commit_tag);
            if (rdy) begin
                qa = q1_addr;
                eb = (qa != 5'd0) && m_busy[qa] && !(hit && qa == rob_commit_addr);
                checks++; if (q1_busy !== eb || q1_tag !== (eb ? m_tag[qa] : 4'd0)) begin errors++;
                    $display("FAIL rand_q1 cyc %0d: got busy=%0h tag=%0h expected %0h/%0h", n, q1_busy, q1_tag, eb, eb ? m_tag[qa] : 4'd0); end
                checks++; if (q1_fwd !== (hit && qa == rob_commit_addr)
                              || q1_fwd_data !== ((hit && qa == rob_commit_addr) ? rob_commit_data : 32'd0)) begin errors++;
                    $display("FAIL rand_q1_fwd cyc %0d: got fwd=%0h data=%0h", n, q1_fwd, q1_fwd_data); end
                qa = q2_addr;
                eb = (qa != 5'd0) && m_busy[qa] && !(hit && qa == rob_commit_addr);
                checks++; if (q2_busy !== eb || q2_tag !== (eb ? m_tag[qa] : 4'd0)
                              || q2_fwd !== (hit && qa == rob_commit_addr)) begin errors++;
                    $display("FAIL rand_q2 cyc %0d: got busy=%0h tag=%0h fwd=%0h expected %0h/%0h/%0h",
                             n, q2_busy, q2_tag, q2_fwd, eb, eb ? m_tag[qa] : 4'd0, hit && qa == rob_commit_addr); end
            end
            @(posedge clk);
            if (!rdy) begin
                m_we = 1'b0;
            end else begin
                m_we = rob_commit_valid && (rob_commit_addr != 5'd0);
                if (m_we) begin
                    m_waddr = rob_commit_addr;
                    m_wdata = rob_commit_data;
                end
                if (rob_flush) begin
                    for (int i = 0; i < 32; i++) begin
                        m_busy[i] = 1'b0;
                        m_tag[i]  = 4'd0;
                    end
                end else begin
                    if (hit) begin
                        m_busy[rob_commit_addr] = 1'b0;
                        m_tag[rob_commit_addr]  = 4'd0;
                    end
                    if (!m_stall && id_dest_valid && id_dest_addr != 5'd0) begin
                        m_busy[id_dest_addr] = 1'b1;
                        m_tag[id_dest_addr]  = id_dest_tag;
                    end
                end
                m_stall = !m_stall && rob_flush;
            end
            cnt = 0;
            for (int i = 0; i < 32; i++) cnt += int'(m_busy[i]);
            #1;
            checks++; if (id_stall !== m_stall || busy_count !== 6'(cnt) || rf_we !== m_we) begin errors++;
                $display("FAIL rand_state cyc %0d: got stall=%0h count=%0d we=%0h expected %0h/%0d/%0h",
                         n, id_stall, busy_count, rf_we, m_stall, cnt, m_we); end
            if (m_we) begin
                checks++; if (rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin errors++;
                    $display("FAIL rand_rf cyc %0d: got %0d/%0h expected %0d/%0h", n, rf_waddr, rf_wdata, m_waddr, m_wdata); end
            end
        end
    endtask

    initial begin
        q1_addr = 5'd0;
        q2_addr = 5'd0;
        idle();
        test_reset();
        test_rename_commit();
        test_tag_mismatch();
        test_back_to_back();
        test_flush();
        test_rdy_low();
        test_x0();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
